// File: rtl/buffer_unpacker.sv
// Captures a DEPTH x WIDTH packed buffer and replays it as WIDTH-bit words,
// lowest slice first, under a valid/ready handshake.
module buffer_unpacker #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] buffer,
  output logic                   busy,
  output logic                   data_valid,
  output logic [WIDTH-1:0]       data,
  output logic                   data_last,
  input  logic                   data_ready,
  output logic                   overrun
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic [WIDTH*DEPTH-1:0] shadow, shadow_n;
  logic [WIDTH-1:0]       data_q, data_n;
  logic                   last_q, last_n;
  logic                   ovr_q, ovr_n;
  logic                   accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      data_q <= data_n;
      last_q <= last_n;
      ovr_q  <= ovr_n;
    end
  end

  // The next word is selected from the next index so data leaves straight from a register.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    data_n   = data_q;
    last_n   = last_q;
    ovr_n    = ovr_q;
    accept   = (state == SEND) && data_ready;

    case (state)
      IDLE: begin
        if (load) begin
          state_n  = SEND;
          shadow_n = buffer;
          idx_n    = '0;
          data_n   = buffer[WIDTH-1:0];
          last_n   = 1'b0;
        end
      end
      SEND: begin
        if (accept && (idx == LAST_IDX)) begin
          idx_n  = '0;
          last_n = 1'b0;
          if (load) begin
            shadow_n = buffer;
            data_n   = buffer[WIDTH-1:0];
          end else begin
            state_n = IDLE;
            data_n  = '0;
          end
        end else begin
          if (accept) begin
            idx_n  = idx + IW'(1);
            data_n = shadow[idx_n*WIDTH +: WIDTH];
            last_n = (idx_n == LAST_IDX);
          end
          if (load) ovr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state == SEND);
  assign data_valid = (state == SEND);
  assign data       = data_q;
  assign data_last  = last_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_buffer_unpacker.sv
// Scoreboard bench for buffer_unpacker: expected words are queued on each honoured
// load and compared as the consumer accepts them; a collector model rebuilds buffers.
module tb_buffer_unpacker;

  localparam int W = 16;
  localparam int D = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           load;
  logic [W*D-1:0] buffer;
  logic           busy;
  logic           data_valid;
  logic [W-1:0]   data;
  logic           data_last;
  logic           data_ready;
  logic           overrun;

  buffer_unpacker #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .buffer     (buffer),
    .busy       (busy),
    .data_valid (data_valid),
    .data       (data),
    .data_last  (data_last),
    .data_ready (data_ready),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int unsigned    n_checks = 0;
  int unsigned    n_fail   = 0;
  logic [W:0]     exp_q[$];
  logic [W*D-1:0] src_q[$];
  logic [W*D-1:0] coll;
  int unsigned    coll_cnt = 0;
  int unsigned    n_acc    = 0;
  int unsigned    n_last   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W*D-1:0] make_buf(input logic [W-1:0] base);
    logic [W*D-1:0] b;
    for (int i = 0; i < D; i++) b[i*W +: W] = base + W'(i);
    return b;
  endfunction

  task automatic push_buf(input logic [W*D-1:0] b);
    for (int i = 0; i < D; i++) exp_q.push_back({(i == D-1), b[i*W +: W]});
    src_q.push_back(b);
  endtask

  // Drive a load from IDLE for one edge and queue its words.
  task automatic do_load(input logic [W*D-1:0] b);
    load   = 1'b1;
    buffer = b;
    push_buf(b);
    step();
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget, output int unsigned n);
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_word(input string tag, input logic [W-1:0] w);
    int unsigned n = 0;
    while (!(data_valid && data == w) && n < 50) begin
      step();
      n++;
    end
    check(tag, {data_valid, data}, {1'b1, w});
  endtask

  // Consumer side: scoreboard pop plus word collector on every accept.
  always @(negedge clock) begin
    if (reset_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("word", {data_last, data}, exp_q.pop_front());
      coll[coll_cnt*W +: W] = data;
      coll_cnt++;
      n_acc++;
      if (data_last) begin
        n_last++;
        if (src_q.size() != 0) check("loopback_buf", coll, src_q.pop_front());
        coll_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, acc0, last0;
    logic [W*D-1:0] a, b;

    reset_n    = 1'b0;
    load       = 1'b0;
    buffer     = '0;
    data_ready = 1'b0;
    #12;
    check("rst_outputs", {busy, data_valid, data, data_last, overrun}, '0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Basic transfer with one-cycle latency and DEPTH valid cycles.
    data_ready = 1'b1;
    acc0 = n_acc; last0 = n_last;
    check("idle_outputs", {busy, data_valid, data, data_last}, '0);
    do_load(make_buf(16'h0000));
    check("latency_word0", {busy, data_valid, data, data_last}, {1'b1, 1'b1, 16'h0000, 1'b0});
    wait_idle("basic_idle", 20, n);
    check("basic_cycles", n, 8);
    check("basic_count", n_acc - acc0, 8);
    check("basic_lasts", n_last - last0, 1);
    check("basic_after", {data_valid, data, data_last}, '0);

    // Backpressure: word 2 held for 4 cycles.
    acc0 = n_acc;
    do_load(make_buf(16'h0000));
    wait_word("bp_find2", 16'h0002);
    data_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_hold", {data_valid, data, data_last}, {1'b1, 16'h0002, 1'b0});
      step();
    end
    check("bp_hold4", {data_valid, data}, {1'b1, 16'h0002});
    data_ready = 1'b1;
    wait_idle("bp_idle", 20, n);
    check("bp_cycles", n, 6);
    check("bp_count", n_acc - acc0, 8);

    // Back-to-back: 16 consecutive valid cycles, two lasts.
    acc0 = n_acc; last0 = n_last;
    a = make_buf(16'h00A0);
    b = make_buf(16'h00B0);
    do_load(a);
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", data_valid, 1'b1);
      if (i == 7) begin
        load   = 1'b1;
        buffer = b;
        push_buf(b);
      end
      step();
      load = 1'b0;
    end
    check("b2b_done", {busy, data_valid}, 2'b00);
    check("b2b_count", n_acc - acc0, 16);
    check("b2b_lasts", n_last - last0, 2);
    check("b2b_no_overrun", overrun, 1'b0);

    // Overrun: load during word 3 is ignored and sticks.
    acc0 = n_acc;
    do_load(make_buf(16'h0100));
    wait_word("ovr_find3", 16'h0103);
    load   = 1'b1;
    buffer = '1;
    step();
    load = 1'b0;
    check("ovr_set", overrun, 1'b1);
    check("ovr_continue", {data_valid, data}, {1'b1, 16'h0104});
    wait_idle("ovr_idle", 20, n);
    check("ovr_sticky", overrun, 1'b1);
    do_load(make_buf(16'h0200));
    check("ovr_reload", {data_valid, data}, {1'b1, 16'h0200});
    wait_idle("ovr_idle2", 20, n);
    check("ovr_count", n_acc - acc0, 16);
    check("ovr_still", overrun, 1'b1);

    // Asynchronous reset mid-transfer while word 5 is offered.
    do_load(make_buf(16'h0300));
    wait_word("rst_find5", 16'h0305);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid", {busy, data_valid, data, data_last, overrun}, '0);
    exp_q.delete();
    src_q.delete();
    coll_cnt = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    acc0 = n_acc;
    do_load(make_buf(16'h1000));
    check("rst_reload", {data_valid, data}, {1'b1, 16'h1000});
    wait_idle("rst_idle", 20, n);
    check("rst_count", n_acc - acc0, 8);

    // Loopback with random buffers and random backpressure.
    for (int it = 0; it < 50; it++) begin
      data_ready = 1'b1;
      do_load({$urandom, $urandom, $urandom, $urandom});
      n = 0;
      while (busy && n < 200) begin
        data_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check("loop_idle", busy, 1'b0);
    end

    data_ready = 1'b0;
    step();
    check("sb_drained", exp_q.size() + src_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
